// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the round/schedule mixing functions.
package sha256_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 256;
  localparam int unsigned N_WORDS  = 16;
  localparam int unsigned N_STATE  = 8;
  localparam int unsigned N_ROUNDS = 64;
  localparam int unsigned CNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [WORD_W-1:0] K [N_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [WORD_W-1:0] IV [N_STATE] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
    return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                           input logic [WORD_W-1:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                            input logic [WORD_W-1:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message schedule window; w_out is the word for the current round.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic [BLOCK_W-1:0] block,
  output logic [WORD_W-1:0]  w_out
);

  logic [WORD_W-1:0] w [N_WORDS];
  logic [WORD_W-1:0] w_new;

  assign w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  assign w_out = w[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WORDS; i++) w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < N_WORDS; i++) w[i] <= block[BLOCK_W-1-WORD_W*i -: WORD_W];
    end else if (advance) begin
      for (int i = 0; i < N_WORDS-1; i++) w[i] <= w[i+1];
      w[N_WORDS-1] <= w_new;
    end
  end

endmodule

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression: one round per clock, chaining add at the end.
module sha256_round_engine
  import sha256_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BLOCK_W-1:0]  block_in,
  input  logic [DIGEST_W-1:0] hash_in,
  output logic                busy,
  output logic                done,
  output logic [DIGEST_W-1:0] digest_out
);

  state_t            state, state_next;
  logic              busy_next, done_next, load, advance;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] wv [N_STATE];
  logic [WORD_W-1:0] hv [N_STATE];
  logic [WORD_W-1:0] w_cur, t1, t2;

  sha256_msg_sched u_sched (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (advance),
    .block   (block_in),
    .w_out   (w_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ROUND;
        end
      end
      ROUND: begin
        advance = 1'b1;
        if (cnt == CNT_W'(N_ROUNDS - 1)) state_next = FINAL;
      end
      FINAL: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign t1 = wv[7] + big_sigma1(wv[4]) + ch(wv[4], wv[5], wv[6]) + K[cnt] + w_cur;
  assign t2 = big_sigma0(wv[0]) + maj(wv[0], wv[1], wv[2]);

  // wv[0..7] hold a..h; hv holds the chaining value for the final add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      digest_out <= '0;
      for (int i = 0; i < N_STATE; i++) begin
        wv[i] <= '0;
        hv[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            cnt <= '0;
            for (int i = 0; i < N_STATE; i++) begin
              hv[i] <= hash_in[DIGEST_W-1-WORD_W*i -: WORD_W];
              wv[i] <= hash_in[DIGEST_W-1-WORD_W*i -: WORD_W];
            end
          end
        end
        ROUND: begin
          wv[0] <= t1 + t2;
          wv[1] <= wv[0];
          wv[2] <= wv[1];
          wv[3] <= wv[2];
          wv[4] <= wv[3] + t1;
          wv[5] <= wv[4];
          wv[6] <= wv[5];
          wv[7] <= wv[6];
          cnt   <= cnt + CNT_W'(1);
        end
        FINAL: begin
          for (int i = 0; i < N_STATE; i++)
            digest_out[DIGEST_W-1-WORD_W*i -: WORD_W] <= hv[i] + wv[i];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Scoreboard bench for sha256_round_engine using known SHA-256 digests.
module tb_sha256_round_engine;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic [255:0] hash_in = '0;
  logic         busy, done;
  logic [255:0] digest_out;

  sha256_round_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .block_in   (block_in),
    .hash_in    (hash_in),
    .busy       (busy),
    .done       (done),
    .digest_out (digest_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] dig;
    int unsigned  cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  int unsigned  checks = 0;
  int unsigned  passes = 0;
  int unsigned  dones  = 0;
  logic [255:0] last_dig = '0;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_L1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_L2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_L1 =
    256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] D_L2 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [255:0] iv_flat;
  initial for (int i = 0; i < 8; i++) iv_flat[255-32*i -: 32] = IV[i];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks handshake invariants.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_dig = '0;
    end else begin
      check("busy_done_overlap", 256'(busy & done), 256'd0);
      if (done) begin
        dones++;
        if (sb.size() == 0) begin
          check("unexpected_done", 256'd1, 256'd0);
        end else begin
          cur = sb.pop_front();
          check("digest", digest_out, cur.dig);
          check("done_cycle", 256'(cyc), 256'(cur.cyc));
        end
        last_dig = digest_out;
      end else begin
        check("digest_hold", digest_out, last_dig);
      end
    end
  end

  task automatic expect_at(input logic [255:0] dig, input int unsigned accept_cyc);
    exp_t e;
    e.dig = dig;
    e.cyc = accept_cyc + 65;
    sb.push_back(e);
  endtask

  // Drives one start pulse; returns #1 after the accepting edge with its cycle index.
  task automatic issue(input logic [511:0] blk, input logic [255:0] hin,
                       input logic [255:0] dig, input bit push, output int unsigned n);
    @(negedge clk);
    start    = 1'b1;
    block_in = blk;
    hash_in  = hin;
    @(posedge clk);
    #1;
    n        = cyc;
    start    = 1'b0;
    block_in = {16{$urandom()}};
    hash_in  = {8{$urandom()}};
    if (push) expect_at(dig, n);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    check("drain", 256'(sb.size()), 256'd0);
    sb.delete();
  endtask

  task automatic wait_cyc(input int unsigned target);
    int k = 0;
    while (cyc < target && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned d0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_digest", digest_out, 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(BLK_ABC, iv_flat, D_ABC, 1'b1, n);
    drain();
    issue(BLK_EMPTY, iv_flat, D_EMPTY, 1'b1, n);
    drain();
    issue(BLK_L1, iv_flat, D_L1, 1'b1, n);
    drain();
    issue(BLK_L2, D_L1, D_L2, 1'b1, n);
    drain();

    // Starts during round 10 and at the done-producing edge must be ignored
    d0 = dones;
    issue(BLK_ABC, iv_flat, D_ABC, 1'b1, n);
    wait_cyc(n + 10);
    start = 1'b1; block_in = BLK_EMPTY; hash_in = '0;
    @(posedge clk); #1 start = 1'b0;
    wait_cyc(n + 64);
    start = 1'b1; block_in = BLK_EMPTY; hash_in = '0;
    @(posedge clk); #1 start = 1'b0;
    drain();
    repeat (140) @(posedge clk);
    check("one_done_per_start", 256'(dones - d0), 256'd1);

    // Asynchronous abort mid-operation, then a clean restart
    issue(BLK_ABC, iv_flat, D_ABC, 1'b0, n);
    wait_cyc(n + 30);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 256'(busy), 256'd0);
    check("abort_done", 256'(done), 256'd0);
    check("abort_digest", digest_out, 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(BLK_ABC, iv_flat, D_ABC, 1'b1, n);
    drain();

    // Start held high: a new block is accepted on the first edge after each done
    @(negedge clk);
    start = 1'b1; block_in = BLK_ABC; hash_in = iv_flat;
    @(posedge clk); #1;
    n = cyc;
    expect_at(D_ABC, n);
    block_in = BLK_EMPTY;
    wait_cyc(n + 66);
    expect_at(D_EMPTY, n + 66);
    block_in = BLK_ABC;
    wait_cyc(n + 132);
    expect_at(D_ABC, n + 132);
    start = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d want done", cyc);
    $fatal(1);
  end

endmodule
